// File: rtl/ifu.sv
// Instruction fetch unit: issues one fetch at a time, holds the returned word for
// decode, and follows control-flow redirects while dropping stale responses.
// Optional feature macro IFU_MISALIGN_CHK_EN: a redirect to a non-word-aligned
// target raises the sticky misalign_fault output and parks the unit in IDLE.
`timescale 1ns/1ps

module ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
`ifdef IFU_MISALIGN_CHK_EN
  ,
  output logic        misalign_fault
`endif
);

  typedef enum logic [2:0] {
    ST_REQ   = 3'd0,
    ST_WAIT  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_IDLE  = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [63:0] pc_r;
  logic [31:0] inst_r;
  logic        redirect_go_s;
  logic        misalign_s;
  logic [63:0] target_s;
  logic        req_valid_s;
  logic        inst_valid_s;

  // IDLE is terminal until reset, so redirects there are ignored
  assign redirect_go_s = redirect_valid && (state_r != ST_IDLE);

`ifdef IFU_MISALIGN_CHK_EN
  logic fault_r;

  assign misalign_s     = |redirect_pc[1:0];
  assign target_s       = redirect_pc;
  assign misalign_fault = fault_r;

  // Sticky fault flag, set by any misaligned redirect and cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_r <= 1'b0;
    end else if (redirect_go_s && misalign_s) begin
      fault_r <= 1'b1;
    end else begin
      fault_r <= fault_r;
    end
  end
`else
  logic unused_lsb_s;

  // Low target bits are forced to zero; they cannot cause a fault in this build
  assign misalign_s   = 1'b0;
  assign target_s     = {redirect_pc[63:2], 2'b00};
  assign unused_lsb_s = ^redirect_pc[1:0];
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_REQ;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a redirect outranks every other transition in its cycle
  always_comb begin
    state_s = state_r;
    if (redirect_go_s && misalign_s) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_REQ: begin
          if (redirect_go_s) begin
            // an accepted request still owes a response, which must be drained
            state_s = imem_req_ready ? ST_DRAIN : ST_REQ;
          end else if (imem_req_ready) begin
            state_s = ST_WAIT;
          end else begin
            state_s = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (redirect_go_s) begin
            state_s = imem_resp_valid ? ST_REQ : ST_DRAIN;
          end else if (imem_resp_valid) begin
            state_s = ST_HOLD;
          end else begin
            state_s = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (redirect_go_s || inst_ready) begin
            state_s = ST_REQ;
          end else begin
            state_s = ST_HOLD;
          end
        end
        ST_DRAIN: begin
          state_s = imem_resp_valid ? ST_REQ : ST_DRAIN;
        end
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_REQ;
        end
      endcase
    end
  end

  // Output decode, derived purely from the state register
  always_comb begin
    req_valid_s  = 1'b0;
    inst_valid_s = 1'b0;
    case (state_r)
      ST_REQ:   req_valid_s  = 1'b1;
      ST_HOLD:  inst_valid_s = 1'b1;
      ST_WAIT,
      ST_DRAIN,
      ST_IDLE: begin
        req_valid_s  = 1'b0;
        inst_valid_s = 1'b0;
      end
      default: begin
        req_valid_s  = 1'b0;
        inst_valid_s = 1'b0;
      end
    endcase
  end

  // Program counter: redirect target wins, otherwise advance on consumption
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else if (redirect_go_s) begin
      pc_r <= target_s;
    end else if ((state_r == ST_HOLD) && inst_ready) begin
      pc_r <= pc_r + 64'd4;
    end else begin
      pc_r <= pc_r;
    end
  end

  // Instruction register, loaded only by a live (non-redirected) response in WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_r <= 32'h0000_0000;
    end else if ((state_r == ST_WAIT) && imem_resp_valid && !redirect_go_s) begin
      inst_r <= imem_resp_data;
    end else begin
      inst_r <= inst_r;
    end
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = pc_r;
  assign inst_valid     = inst_valid_s;
  assign inst           = inst_r;
  assign pc             = pc_r;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of the expected instruction stream.
`timescale 1ns/1ps

module tb_ifu;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
`ifdef IFU_MISALIGN_CHK_EN
  logic        misalign_fault;
`endif

  int total = 0;
  int bad = 0;

  // model: next address the fetch stream must deliver, plus the memory's outstanding slot
  logic [63:0] exp_pc = RST_PC;
  bit          pend = 1'b0;
  logic [63:0] pend_addr = 64'h0;
  int          lat = 0;
  int          delivered = 0;

  // drive knobs for the next cycle
  bit          rnd = 1'b0;
  logic        drv_ready = 1'b0;
  logic        drv_iready = 1'b0;
  logic        drv_redir = 1'b0;
  logic [63:0] drv_rpc = 64'h0;
  int          drv_lat = 0;

  always #5 clk = ~clk;

  ifu #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .pc              (pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
`ifdef IFU_MISALIGN_CHK_EN
    ,
    .misalign_fault  (misalign_fault)
`endif
  );

  // instruction memory contents: a fixed word at the reset vector, a hash elsewhere
  function automatic logic [31:0] memword(input logic [63:0] a);
    logic [31:0] h;
    if (a == RST_PC) return 32'h0010_0093;
    h = a[31:0] * 32'h9E37_79B1;
    return h ^ a[63:32] ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  // one clock: apply inputs, check visible state against the model, advance the model
  task automatic tick();
    bit          rf, pf, cf, rd;
    logic [63:0] af, tg;
    if (rnd) begin
      drv_ready  = 1'($urandom_range(0, 1));
      drv_iready = 1'($urandom_range(0, 1));
      drv_redir  = ($urandom_range(0, 19) == 0);
`ifdef IFU_MISALIGN_CHK_EN
      drv_rpc    = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_0FFC)};
`else
      drv_rpc    = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_0FFF)};
`endif
    end
    imem_req_ready = drv_ready;
    inst_ready     = drv_iready;
    redirect_valid = drv_redir;
    redirect_pc    = drv_rpc;
    if (pend && lat == 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memword(pend_addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      if (pend) lat--;
    end
    rf = imem_req_valid && imem_req_ready;
    af = imem_req_addr;
    pf = imem_resp_valid;
    rd = redirect_valid;
    tg = redirect_pc;
    cf = inst_valid && inst_ready && !redirect_valid;
    if (inst_valid) begin
      chk("held_pc", pc, exp_pc);
      chk("held_inst", 64'(inst), 64'(memword(exp_pc)));
    end
    if (imem_req_valid) chk("req_addr", imem_req_addr, exp_pc);
    @(posedge clk);
    #1;
    if (rd) exp_pc = {tg[63:2], 2'b00};
    else if (cf) begin
      exp_pc = exp_pc + 64'd4;
      delivered++;
    end
    if (rf) chk("one_outstanding", 64'(pend), 64'd0);
    if (pf) pend = 1'b0;
    if (rf) begin
      pend      = 1'b1;
      pend_addr = af;
      lat       = rnd ? int'($urandom_range(0, 3)) : drv_lat;
    end
  endtask

  task automatic idle_drv();
    drv_ready  = 1'b0;
    drv_iready = 1'b0;
    drv_redir  = 1'b0;
    drv_lat    = 0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'd1);
    chk({tag, "_inst_valid"}, 64'(inst_valid), 64'd0);
    chk({tag, "_pc"}, pc, RST_PC);
    chk({tag, "_addr"}, imem_req_addr, RST_PC);
    chk({tag, "_inst"}, 64'(inst), 64'd0);
  endtask

  initial begin
    // asynchronous reset, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    reset_checks("rst");
`ifdef IFU_MISALIGN_CHK_EN
    chk("rst_fault", 64'(misalign_fault), 64'd0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_pc = RST_PC;

    // first fetch: ready at once, response the next cycle
    drv_ready = 1'b1;
    drv_lat   = 0;
    tick();
    chk("wait_req_valid", 64'(imem_req_valid), 64'd0);
    chk("wait_inst_valid", 64'(inst_valid), 64'd0);
    drv_ready = 1'b0;
    tick();
    chk("first_inst_valid", 64'(inst_valid), 64'd1);
    chk("first_inst", 64'(inst), 64'h0010_0093);
    chk("first_pc", pc, 64'h8000_0000);

    // decode stalls for five cycles: word and pc must not move
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 64'(inst_valid), 64'd1);
      chk("stall_inst", 64'(inst), 64'h0010_0093);
      chk("stall_pc", pc, 64'h8000_0000);
    end

    // consume: next request at pc+4
    drv_iready = 1'b1;
    tick();
    drv_iready = 1'b0;
    chk("seq_req_valid", 64'(imem_req_valid), 64'd1);
    chk("seq_addr", imem_req_addr, 64'h8000_0004);

    // redirect while waiting: the late response must be dropped
    drv_ready = 1'b1;
    drv_lat   = 2;
    tick();
    drv_ready = 1'b0;
    drv_redir = 1'b1;
    drv_rpc   = 64'h8000_0100;
    tick();
    drv_redir = 1'b0;
    chk("drain_req_valid", 64'(imem_req_valid), 64'd0);
    chk("drain_pc", pc, 64'h8000_0100);
    for (int i = 0; i < 10; i++) begin
      if (imem_req_valid) break;
      chk("drain_no_inst", 64'(inst_valid), 64'd0);
      tick();
    end
    chk("drain_exit", 64'(imem_req_valid), 64'd1);
    chk("drain_addr", imem_req_addr, 64'h8000_0100);

    // fetch at the target, then redirect concurrent with consumption
    drv_ready = 1'b1;
    drv_lat   = 0;
    tick();
    drv_ready = 1'b0;
    tick();
    chk("tgt_inst", 64'(inst), 64'(memword(64'h8000_0100)));
    drv_iready = 1'b1;
    drv_redir  = 1'b1;
    drv_rpc    = 64'h8000_0200;
    tick();
    idle_drv();
    chk("hold_redir_valid", 64'(imem_req_valid), 64'd1);
    chk("hold_redir_addr", imem_req_addr, 64'h8000_0200);

    // pc wraps from the top of the address space to zero
    drv_redir = 1'b1;
    drv_rpc   = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    drv_redir = 1'b0;
    drv_ready = 1'b1;
    tick();
    drv_ready = 1'b0;
    tick();
    chk("wrap_hold_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    drv_iready = 1'b1;
    tick();
    drv_iready = 1'b0;
    chk("wrap_valid", 64'(imem_req_valid), 64'd1);
    chk("wrap_addr", imem_req_addr, 64'h0);

    // randomized traffic against the stream model
    rnd = 1'b1;
    for (int i = 0; i < 3000; i++) tick();
    rnd = 1'b0;
    idle_drv();
    chk("progress", 64'(delivered > 100), 64'd1);

    // reset in the middle of traffic; memory is reset with it
    rst_n = 1'b0;
    pend = 1'b0;
    imem_resp_valid = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    #1;
    reset_checks("mid_rst");
    exp_pc = RST_PC;
    @(posedge clk);
    #1 rst_n = 1'b1;
    drv_ready = 1'b1;
    tick();
    drv_ready = 1'b0;
    tick();
    chk("post_rst_valid", 64'(inst_valid), 64'd1);
    chk("post_rst_inst", 64'(inst), 64'h0010_0093);

`ifdef IFU_MISALIGN_CHK_EN
    // misaligned redirect parks the unit until reset
    drv_redir = 1'b1;
    drv_rpc   = 64'h8000_0102;
    tick();
    drv_redir = 1'b0;
    drv_ready = 1'b1;
    chk("mis_fault", 64'(misalign_fault), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("mis_no_req", 64'(imem_req_valid), 64'd0);
      chk("mis_no_inst", 64'(inst_valid), 64'd0);
      tick();
    end
    idle_drv();
    rst_n = 1'b0;
    pend = 1'b0;
    #1;
    chk("mis_rst_fault", 64'(misalign_fault), 64'd0);
    chk("mis_rst_req", 64'(imem_req_valid), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 SHALL provide parameter: RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset.
REQ-002 SHALL provide port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: imem_req_valid  output  1  fetch request valid.
REQ-005 SHALL provide port: imem_req_ready  input  1  memory accepts request.
REQ-006 SHALL provide port: imem_req_addr  output  64  fetch address (equals pc).
REQ-007 SHALL provide port: imem_resp_valid  input  1  fetch data valid, one pulse per accepted request.
REQ-008 SHALL provide port: imem_resp_data  input  32  fetched instruction word.
REQ-009 SHALL provide port: inst_valid  output  1  instruction available to decode stage.
REQ-010 SHALL provide port: inst_ready  input  1  decode stage consumes instruction.
REQ-011 SHALL provide port: inst  output  32  held instruction word.
REQ-012 SHALL provide port: pc  output  64  address of current or held instruction.
REQ-013 SHALL provide port: redirect_valid  input  1  control-flow redirect (JAL/JALR/branch taken).
REQ-014 SHALL provide port: redirect_pc  input  64  redirect target.
REQ-015 SHALL provide port: misalign_fault  output  1  sticky fault, present only with IFU_MISALIGN_CHK_EN.

Function
REQ-016 SHALL implement states REQ, WAIT, HOLD, DRAIN, IDLE, one-hot or binary.
REQ-017 SHALL drive imem_req_valid=1 only in REQ; imem_req_addr=pc at all times.
REQ-018 SHALL drive inst_valid=1 only in HOLD; inst and pc stable throughout HOLD.
REQ-019 REQ: on imem_req_ready -> WAIT; else remain REQ.
REQ-020 WAIT: on imem_resp_valid capture imem_resp_data into inst, -> HOLD.
REQ-021 HOLD: on inst_ready, pc <= pc+4 (modulo 2^64, wraps), -> REQ.
REQ-022 SHALL ignore imem_resp_valid in REQ, HOLD, IDLE.
REQ-023 redirect_valid SHALL take priority over every other transition in the same cycle: pc <= redirect_pc.
REQ-024 Redirect in REQ without imem_req_ready, or in HOLD (regardless of inst_ready) -> REQ; held instruction discarded.
REQ-025 Redirect in WAIT without imem_resp_valid, or in REQ with imem_req_ready -> DRAIN (one response outstanding).
REQ-026 Redirect in WAIT with imem_resp_valid -> REQ; response discarded.
REQ-027 DRAIN: discard next imem_resp_valid, -> REQ; redirect in DRAIN updates pc, stays DRAIN unless response arrives same cycle (-> REQ).
REQ-028 SHALL reach HOLD at earliest 2 cycles after entering REQ (ready same cycle, response next cycle); no combinational path from imem_resp_data to inst.
REQ-029 SHALL keep at most one request outstanding.

Reset
REQ-030 On rst_n low, immediately: state=REQ, pc=RESET_PC, inst=32'h0, misalign_fault=0; hence imem_req_valid=1, inst_valid=0.
REQ-031 Reset mid-transaction SHALL abandon any outstanding response; memory side is reset concurrently.

Configuration
REQ-032 With IFU_MISALIGN_CHK_EN defined: redirect with redirect_pc[1:0]!=0 sets misalign_fault=1 and -> IDLE; IDLE issues nothing, holds until reset.
REQ-033 Without IFU_MISALIGN_CHK_EN: misalign_fault port absent, redirect_pc[1:0] treated as 2'b00, IDLE unreachable.

Verification
REQ-034 Reset release, ready=1, resp next cycle with 32'h00100093 -> inst_valid at cycle 2, inst=32'h00100093, pc=64'h80000000.
REQ-035 HOLD with inst_ready=1 -> next request addr 64'h80000004; inst_ready held low 5 cycles -> inst/pc unchanged.
REQ-036 Redirect to 64'h80000100 in WAIT -> DRAIN, stale response dropped, next request addr 64'h80000100.
REQ-037 Redirect to 64'h80000200 concurrent with inst_ready in HOLD -> next addr 64'h80000200, not pc+4.
REQ-038 pc=64'hFFFF_FFFF_FFFF_FFFC consumed -> next addr 64'h0.
REQ-039 With IFU_MISALIGN_CHK_EN, redirect to 64'h80000102 -> misalign_fault=1, imem_req_valid=0 until rst_n low.
